// File: rtl/gpio_pkg.sv
// gpio_pkg: definitions shared by the GPIO input path.
//   GPIO_WIDTH              - default number of GPIO bits
//   gpio_data_t             - one full GPIO pin vector
//   DEFAULT_DEBOUNCE_CYCLES - default number of stable cycles needed to accept a new level
package gpio_pkg;

  localparam int GPIO_WIDTH              = 32;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef logic [GPIO_WIDTH-1:0] gpio_data_t;

endpackage : gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: receive path for a single GPIO pin.
//   Two-flop synchronizer, optional debounce counter, stable level flop and
//   one-cycle rise/fall pulses. The pulses are registered so that they appear
//   in the same cycle that stable_o first shows the new level.
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   pin_i         raw asynchronous pin
//   debounce_en_i 1 = require DEBOUNCE_CYCLES consecutive mismatches, 0 = bypass
//   stable_o      synchronized (and debounced) level
//   rise_o        one-cycle pulse when stable_o goes 0 -> 1
//   fall_o        one-cycle pulse when stable_o goes 1 -> 0
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  input  logic debounce_en_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rise_r;
  logic             fall_r;

  logic             stable_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             mismatch_s;

  // Next stable level and debounce count from the synchronized pin.
  always_comb begin
    stable_next_s = stable_r;
    cnt_next_s    = CNT_ZERO;
    mismatch_s    = sync2_r ^ stable_r;
    if (debounce_en_i) begin
      if (mismatch_s) begin
        // The accepting mismatch is the DEBOUNCE_CYCLES-th in a row.
        if (cnt_r == CNT_MAX) begin
          stable_next_s = sync2_r;
          cnt_next_s    = CNT_ZERO;
        end else begin
          stable_next_s = stable_r;
          cnt_next_s    = cnt_r + CNT_ONE;
        end
      end else begin
        // Any agreeing cycle restarts the count, so short glitches are dropped.
        stable_next_s = stable_r;
        cnt_next_s    = CNT_ZERO;
      end
    end else begin
      stable_next_s = sync2_r;
      cnt_next_s    = CNT_ZERO;
    end
  end

  // Synchronizer, counter, stable level and edge pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      sync1_r  <= pin_i;
      sync2_r  <= sync1_r;
      stable_r <= stable_next_s;
      cnt_r    <= cnt_next_s;
      rise_r   <= stable_next_s & ~stable_r;
      fall_r   <= ~stable_next_s & stable_r;
    end
  end

  assign stable_o = stable_r;
  assign rise_o   = rise_r;
  assign fall_o   = fall_r;

endmodule : gpio_debounce_bit

// File: rtl/gpio_input_ctrl.sv
// gpio_input_ctrl: receiving stage for the GPIO pin bus.
//   Every bit is synchronized, optionally debounced and edge-detected by its
//   own gpio_debounce_bit. Enabled edges set a sticky per-bit status that is
//   cleared by write-1-to-clear pulses; irq_o is the OR of that status.
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   gpio_i         raw asynchronous pin values
//   debounce_en_i  1 = debounce, 0 = bypass
//   rise_en_i      per-bit rising-edge interrupt enable
//   fall_en_i      per-bit falling-edge interrupt enable
//   irq_clr_i      per-bit write-1-to-clear for irq_status_o
//   gpio_o         stable pin values
//   rise_o         per-bit one-cycle rising-edge pulse
//   fall_o         per-bit one-cycle falling-edge pulse
//   irq_status_o   sticky edge-event status
//   irq_o          OR of irq_status_o
module gpio_input_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] gpio_i,
  input  logic             debounce_en_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_status_o,
  output logic             irq_o
);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_err
    $error("gpio_input_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] stable_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] status_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .pin_i         (gpio_i[i]),
      .debounce_en_i (debounce_en_i),
      .stable_o      (stable_s[i]),
      .rise_o        (rise_s[i]),
      .fall_o        (fall_s[i])
    );
  end

  // Enabled edge events that set status this cycle.
  always_comb begin
    set_s = (rise_s & rise_en_i) | (fall_s & fall_en_i);
  end

  // Sticky status: clear first, then OR in new events so a colliding set wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      status_r <= '0;
    end else begin
      status_r <= (status_r & ~irq_clr_i) | set_s;
    end
  end

  assign gpio_o       = stable_s;
  assign rise_o       = rise_s;
  assign fall_o       = fall_s;
  assign irq_status_o = status_r;
  // Reduction of a register only, so the line cannot glitch.
  assign irq_o        = |status_r;

endmodule : gpio_input_ctrl

// File: tb/tb_gpio_input_ctrl.sv
// Directed-vector bench for gpio_input_ctrl with a queue-based scoreboard.
// The driver applies one vector per cycle at the falling edge and pushes the
// hand-computed outputs expected after the following rising edge; the monitor
// pops one entry per rising edge and compares.
module tb_gpio_input_ctrl;
  import gpio_pkg::*;

  typedef struct packed {
    gpio_data_t g;
    gpio_data_t r;
    gpio_data_t f;
    gpio_data_t s;
    logic       i;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_s = 1'b1;
  gpio_data_t gpio_s = '0;
  logic       den_s = 1'b1;
  gpio_data_t rise_en_s = '0;
  gpio_data_t fall_en_s = '0;
  gpio_data_t clr_s = '0;
  gpio_data_t gpio_o_s;
  gpio_data_t rise_o_s;
  gpio_data_t fall_o_s;
  gpio_data_t stat_o_s;
  logic       irq_o_s;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  gpio_input_ctrl #(
    .WIDTH           (GPIO_WIDTH),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_s),
    .gpio_i        (gpio_s),
    .debounce_en_i (den_s),
    .rise_en_i     (rise_en_s),
    .fall_en_i     (fall_en_s),
    .irq_clr_i     (clr_s),
    .gpio_o        (gpio_o_s),
    .rise_o        (rise_o_s),
    .fall_o        (fall_o_s),
    .irq_status_o  (stat_o_s),
    .irq_o         (irq_o_s)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input gpio_data_t act, input gpio_data_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp("gpio_o", gpio_o_s, e.g);
        cmp("rise_o", rise_o_s, e.r);
        cmp("fall_o", fall_o_s, e.f);
        cmp("irq_status_o", stat_o_s, e.s);
        cmp("irq_o", {31'd0, irq_o_s}, {31'd0, e.i});
      end
    end
  end

  task automatic vec(input gpio_data_t g, input logic rst, input gpio_data_t clr,
                     input gpio_data_t eg, input gpio_data_t er, input gpio_data_t ef,
                     input gpio_data_t es);
    exp_t e;
    @(negedge clk);
    gpio_s = g;
    rst_s  = rst;
    clr_s  = clr;
    e.g = eg; e.r = er; e.f = ef; e.s = es; e.i = |es;
    exp_q.push_back(e);
  endtask

  initial begin
    gpio_data_t z;
    z = '0;
    // 1. reset, idle, then bit 0 held high: accepted 5 edges after capture.
    vec(z, 1'b1, z, z, z, z, z);
    vec(z, 1'b1, z, z, z, z, z);
    for (int i = 0; i < 3; i++) vec(z, 1'b0, z, z, z, z, z);
    for (int i = 0; i < 7; i++)
      vec(32'h1, 1'b0, z, (i >= 5) ? 32'h1 : z, (i == 5) ? 32'h1 : z, z, z);

    // 2. bit 3: 3-cycle glitch rejected, 4-cycle pulse accepted.
    for (int i = 0; i < 8; i++)
      vec((i < 3) ? 32'h9 : 32'h1, 1'b0, z, 32'h1, z, z, z);
    for (int i = 0; i < 11; i++)
      vec((i < 4) ? 32'h9 : 32'h1, 1'b0, z,
          (i >= 5 && i <= 8) ? 32'h9 : 32'h1,
          (i == 5) ? 32'h8 : z, (i == 9) ? 32'h8 : z, z);

    // 3. bypass: bit 7 toggles every cycle, follows with 2-edge latency.
    @(negedge clk);
    den_s = 1'b0;
    exp_q.push_back('{g: 32'h1, r: z, f: z, s: z, i: 1'b0});
    for (int i = 0; i < 8; i++)
      vec(32'h1 | ((i == 0 || i == 2) ? 32'h80 : z), 1'b0, z,
          32'h1 | ((i == 2 || i == 4) ? 32'h80 : z),
          (i == 2 || i == 4) ? 32'h80 : z,
          (i == 3 || i == 5) ? 32'h80 : z, z);

    // 4. interrupts on bit 0: rise enabled, fall not.
    @(negedge clk);
    den_s     = 1'b1;
    rise_en_s = 32'h1;
    fall_en_s = 32'h0;
    exp_q.push_back('{g: 32'h1, r: z, f: z, s: z, i: 1'b0});
    for (int i = 0; i < 3; i++) vec(32'h1, 1'b0, z, 32'h1, z, z, z);
    for (int i = 0; i < 6; i++)
      vec(z, 1'b0, z, (i < 5) ? 32'h1 : z, z, (i == 5) ? 32'h1 : z, z);
    for (int i = 0; i < 7; i++)
      vec(32'h1, 1'b0, z, (i >= 5) ? 32'h1 : z, (i == 5) ? 32'h1 : z, z,
          (i == 6) ? 32'h1 : z);
    for (int i = 0; i < 7; i++)
      vec(z, 1'b0, z, (i < 5) ? 32'h1 : z, z, (i == 5) ? 32'h1 : z, 32'h1);
    vec(z, 1'b0, 32'h1, z, z, z, z);
    vec(z, 1'b0, z, z, z, z, z);

    // 5. clear colliding with an enabled rise; clear of an idle bit; final clear.
    for (int i = 0; i < 9; i++)
      vec(32'h1, 1'b0,
          (i == 6 || i == 8) ? 32'h1 : ((i == 7) ? 32'h2 : z),
          (i >= 5) ? 32'h1 : z, (i == 5) ? 32'h1 : z, z,
          (i == 6 || i == 7) ? 32'h1 : z);

    // 6. reset while bit 5 is mid-count; full latency again after release.
    for (int i = 0; i < 12; i++)
      vec(32'h21, (i == 4), z,
          (i < 4) ? 32'h1 : ((i >= 10) ? 32'h21 : z),
          (i == 10) ? 32'h21 : z, z, (i == 11) ? 32'h1 : z);

    begin
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain actual=%0d left required=0", exp_q.size());
      end
    end
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_gpio_input_ctrl
